soc_system_pio_shadow_bank: RTL and testbench

- Parametrised successor to the single-register Avalon-MM output PIO.
- Holds CHANNELS output registers, each DATA_WIDTH bits wide, with shadow/active double buffering.
- The HPS writes the shadow registers, then requests a commit. All channels update atomically once the coprocessor deasserts sink_busy, so the image coprocessor never sees a half-updated parameter set (window dimensions, offsets).
- Sits on the lightweight HPS-to-FPGA bridge in soc_system, driving coprocessor configuration inputs.

---
 rtl/soc_system_pio_shadow_pkg.sv | 44 ++++
 rtl/soc_system_pio_shadow_chan.sv | 48 ++++
 rtl/soc_system_pio_shadow_bank.sv | 185 ++++++++++++++++++
 tb/tb_soc_system_pio_shadow_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_shadow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_system_pio_shadow_pkg                                       |
// | Purpose  : Shared address-map helpers, CTRL bit positions and FSM state    |
// |            encoding for the shadow/active PIO bank.                        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package soc_system_pio_shadow_pkg;

    // CTRL write bits
    localparam int unsigned c_ctrl_commit_bit  = 0;
    localparam int unsigned c_ctrl_abort_bit   = 1;
    localparam int unsigned c_ctrl_clr_ovr_bit = 2;

    // CTRL read bits
    localparam int unsigned c_ctrl_pending_bit = 0;
    localparam int unsigned c_ctrl_ovr_bit     = 2;

    typedef enum logic [0:0] {
        c_st_idle    = 1'b0,
        c_st_pending = 1'b1
    } state_e;

    // Shadow registers always start at word 0.
    function automatic int unsigned shadow_base();
        return 0;
    endfunction

    // Active (read-only) copies follow the shadow block.
    function automatic int unsigned active_base(input int unsigned channels);
        return channels;
    endfunction

    function automatic int unsigned ctrl_offset(input int unsigned channels);
        return 2 * channels;
    endfunction

    function automatic int unsigned count_offset(input int unsigned channels);
        return (2 * channels) + 1;
    endfunction

endpackage : soc_system_pio_shadow_pkg
`default_nettype wire

// File: rtl/soc_system_pio_shadow_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_system_pio_shadow_chan                                      |
// | Purpose  : One shadow/active register pair. The shadow is written from the |
// |            bus; the active copy takes the shadow value on load.            |
// | Ports    : clk, reset (async, active-high)                                 |
// |            wr_en, wr_data  - shadow write                                  |
// |            load            - copy shadow into active                       |
// |            shadow, active  - register contents                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module soc_system_pio_shadow_chan
    import soc_system_pio_shadow_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] shadow,
    output logic [DATA_WIDTH-1:0] active
);

    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_active;

    // A write and a load on the same edge: active takes the pre-write shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (wr_en) begin
                r_shadow <= wr_data;
            end
            if (load) begin
                r_active <= r_shadow;
            end
        end
    end

    assign shadow = r_shadow;
    assign active = r_active;

endmodule : soc_system_pio_shadow_chan
`default_nettype wire

// File: rtl/soc_system_pio_shadow_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : soc_system_pio_shadow_bank                                      |
// | Purpose  : Avalon-MM output PIO with CHANNELS double-buffered registers.   |
// |            Host fills the shadows, then commits; all channels move to the  |
// |            active side together once sink_busy is low.                     |
// | Ports    : clk, reset (async, active-high)                                 |
// |            address, chipselect, write_n, writedata, readdata - Avalon slave|
// |            sink_busy    - holds off a pending commit                       |
// |            out_port     - active registers, channel i at [i*DW +: DW]      |
// |            update_pulse - one cycle high after each transfer               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module soc_system_pio_shadow_bank
    import soc_system_pio_shadow_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           chipselect,
    input  logic                           write_n,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    input  logic                           sink_busy,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_port,
    output logic                           update_pulse
);

    generate
        if ((CHANNELS < 1) || (CHANNELS > 8) ||
            (DATA_WIDTH < 1) || (DATA_WIDTH > 32) ||
            (CNT_WIDTH < 1) || (CNT_WIDTH > 32) ||
            ((2 * CHANNELS + 2) > (1 << ADDR_WIDTH))) begin : g_bad_params
            $error("soc_system_pio_shadow_bank: illegal parameter combination");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] c_ctrl_addr  = ADDR_WIDTH'(ctrl_offset(CHANNELS));
    localparam logic [ADDR_WIDTH-1:0] c_count_addr = ADDR_WIDTH'(count_offset(CHANNELS));

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_overrun;
    logic                  r_update_pulse;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_write;
    logic                  w_ctrl_wr;
    logic                  w_commit;
    logic                  w_abort;
    logic                  w_clr_ovr;
    logic                  w_load;
    logic                  w_ovr_set;
    logic                  w_unused_wdata;

    logic [DATA_WIDTH-1:0] w_shadow [CHANNELS];
    logic [DATA_WIDTH-1:0] w_active [CHANNELS];

    assign w_write   = chipselect && !write_n;
    assign w_ctrl_wr = w_write && (address == c_ctrl_addr);
    assign w_commit  = w_ctrl_wr && writedata[c_ctrl_commit_bit];
    assign w_abort   = w_ctrl_wr && writedata[c_ctrl_abort_bit];
    assign w_clr_ovr = w_ctrl_wr && writedata[c_ctrl_clr_ovr_bit];

    // Upper writedata bits are dropped when DATA_WIDTH < 32.
    assign w_unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            localparam logic [ADDR_WIDTH-1:0] c_shadow_addr =
                ADDR_WIDTH'(shadow_base() + unsigned'(g));

            soc_system_pio_shadow_chan #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (w_write && (address == c_shadow_addr)),
                .wr_data (writedata[DATA_WIDTH-1:0]),
                .load    (w_load),
                .shadow  (w_shadow[g]),
                .active  (w_active[g])
            );

            assign out_port[g*DATA_WIDTH +: DATA_WIDTH] = w_active[g];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_commit && !w_abort) begin
                    w_state_next = c_st_pending;
                end
            end
            c_st_pending: begin
                if (w_abort) begin
                    w_state_next = c_st_idle;
                end else if (!sink_busy) begin
                    // A COMMIT landing on the transfer edge starts a fresh
                    // commit instead of merging into the one being retired.
                    w_load       = 1'b1;
                    w_state_next = w_commit ? c_st_pending : c_st_idle;
                end else if (w_commit) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status, counter and pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun      <= 1'b0;
            r_update_pulse <= 1'b0;
            r_count        <= '0;
        end else begin
            // Setting has priority over a clear in the same write.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_clr_ovr) begin
                r_overrun <= 1'b0;
            end
            r_update_pulse <= w_load;
            if (w_load) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign update_pulse = r_update_pulse;

    // ------------------------------------------------------------------
    // Zero-latency read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (address == ADDR_WIDTH'(shadow_base() + unsigned'(i))) begin
                    readdata = 32'(w_shadow[i]);
                end
                if (address == ADDR_WIDTH'(active_base(CHANNELS) + unsigned'(i))) begin
                    readdata = 32'(w_active[i]);
                end
            end
            if (address == c_ctrl_addr) begin
                readdata[c_ctrl_pending_bit] = (r_state == c_st_pending);
                readdata[c_ctrl_ovr_bit]     = r_overrun;
            end
            if (address == c_count_addr) begin
                readdata = 32'(r_count);
            end
        end
    end

endmodule : soc_system_pio_shadow_bank
`default_nettype wire

// File: tb/tb_soc_system_pio_shadow_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_soc_system_pio_shadow_bank                                   |
// | Purpose  : Scoreboard bench for the shadow/active PIO bank. Stimulus       |
// |            queues expected read data and expected update pulses; a monitor |
// |            pops and compares whenever a read or a pulse appears.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_soc_system_pio_shadow_bank;

    localparam int CHANNELS   = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int CNT_WIDTH  = 4;
    localparam int PW         = CHANNELS * DATA_WIDTH;

    // Address map for CHANNELS = 4
    localparam int A_SH0 = 0, A_SH1 = 1, A_SH2 = 2, A_SH3 = 3;
    localparam int A_AC0 = 4, A_AC1 = 5, A_AC2 = 6, A_AC3 = 7;
    localparam int A_CTRL = 8, A_COUNT = 9;

    logic                  clk        = 1'b0;
    logic                  reset      = 1'b1;
    logic [ADDR_WIDTH-1:0] address    = '0;
    logic                  chipselect = 1'b0;
    logic                  write_n    = 1'b1;
    logic [31:0]           writedata  = '0;
    logic [31:0]           readdata;
    logic                  sink_busy  = 1'b0;
    logic [PW-1:0]         out_port;
    logic                  update_pulse;

    soc_system_pio_shadow_bank #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .sink_busy    (sink_busy),
        .out_port     (out_port),
        .update_pulse (update_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic [PW-1:0] port;
    } pulse_exp_t;

    rd_exp_t    rd_q[$];
    pulse_exp_t pulse_q[$];

    function automatic logic [PW-1:0] img(input logic [31:0] c3, input logic [31:0] c2,
                                          input logic [31:0] c1, input logic [31:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic bus_write(input int a, input logic [31:0] d);
        address    = ADDR_WIDTH'(a);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int a, input logic [31:0] exp, input string nm);
        rd_exp_t e;
        e.data = exp;
        e.name = nm;
        rd_q.push_back(e);
        address    = ADDR_WIDTH'(a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    // Pulse expected dly clock edges from now, with out_port equal to image.
    task automatic expect_pulse(input int dly, input logic [PW-1:0] image);
        pulse_exp_t p;
        p.cyc  = cyc + dly;
        p.port = image;
        pulse_q.push_back(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_direct(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares on every read and every update pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect && write_n) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected: got readdata=0x%08h expected no read", readdata);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    if (readdata !== e.data) begin
                        failures++;
                        $display("FAIL %s: readdata=0x%08h expected 0x%08h", e.name, readdata, e.data);
                    end
                end
            end
            if (update_pulse) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    failures++;
                    $display("FAIL pulse_unexpected: update_pulse=1 at cycle %0d expected 0", cyc);
                end else begin
                    pulse_exp_t p;
                    p = pulse_q.pop_front();
                    if ((p.cyc != cyc) || (out_port !== p.port)) begin
                        failures++;
                        $display("FAIL pulse: cycle=%0d out_port=0x%0h expected cycle=%0d out_port=0x%0h",
                                 cyc, out_port, p.cyc, p.port);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] img_a;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_direct("reset_out_port", out_port, '0);
        check_direct("reset_update_pulse", PW'(update_pulse), '0);
        reset = 1'b0;
        idle(1);
        for (int a = 0; a < 16; a++) bus_read(a, 32'h0, "reset_read");

        // ---------------- basic commit ----------------
        bus_write(A_SH0, 32'h0000_0140);
        bus_write(A_SH1, 32'h0000_00F0);
        expect_pulse(2, img(0, 0, 32'hF0, 32'h140));
        bus_write(A_CTRL, 32'h1);
        idle(2);
        bus_read(A_AC0, 32'h140, "active0_commit");
        bus_read(A_AC1, 32'hF0,  "active1_commit");
        bus_read(A_COUNT, 32'd1, "count_1");
        bus_read(A_CTRL, 32'h0,  "ctrl_idle");
        bus_read(A_SH0, 32'h140, "shadow0_readback");

        // ---------------- commit held off by sink_busy ----------------
        sink_busy = 1'b1;
        bus_write(A_CTRL, 32'h1);
        idle(20);
        bus_read(A_CTRL, 32'h1, "ctrl_pending_busy");
        bus_read(A_AC0, 32'h140, "active0_held");
        bus_write(A_SH0, 32'h200);
        expect_pulse(1, img(0, 0, 32'hF0, 32'h200));
        sink_busy = 1'b0;
        idle(2);
        bus_read(A_COUNT, 32'd2, "count_2");
        bus_read(A_CTRL, 32'h0, "ctrl_after_release");
        bus_read(A_AC0, 32'h200, "active0_released");

        // ---------------- overrun, clear, abort ----------------
        sink_busy = 1'b1;
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h5, "ctrl_overrun");
        bus_write(A_CTRL, 32'h5);
        bus_read(A_CTRL, 32'h5, "ovr_set_beats_clear");
        bus_write(A_CTRL, 32'h4);
        bus_read(A_CTRL, 32'h1, "ovr_cleared");
        bus_write(A_SH3, 32'h33);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_CTRL, 32'h0, "abort_beats_commit");
        bus_read(A_AC3, 32'h0, "active3_after_abort");
        sink_busy = 1'b0;
        idle(3);
        bus_read(A_COUNT, 32'd2, "count_after_abort");

        // ---------------- shadow write on the transfer edge ----------------
        bus_write(A_SH2, 32'h11);
        sink_busy = 1'b1;
        bus_write(A_CTRL, 32'h1);
        expect_pulse(1, img(32'h33, 32'h11, 32'hF0, 32'h200));
        sink_busy = 1'b0;
        bus_write(A_SH2, 32'h22);
        idle(1);
        bus_read(A_AC2, 32'h11, "active2_old_value");
        bus_read(A_SH2, 32'h22, "shadow2_new_value");
        bus_read(A_COUNT, 32'd3, "count_3");
        img_a = img(32'h33, 32'h22, 32'hF0, 32'h200);
        expect_pulse(2, img_a);
        bus_write(A_CTRL, 32'h1);
        idle(2);
        bus_read(A_AC2, 32'h22, "active2_new_value");
        bus_read(A_COUNT, 32'd4, "count_4");

        // ---------------- COMMIT on the transfer edge ----------------
        sink_busy = 1'b1;
        bus_write(A_CTRL, 32'h1);
        expect_pulse(1, img_a);
        expect_pulse(2, img_a);
        sink_busy = 1'b0;
        bus_write(A_CTRL, 32'h1);
        idle(2);
        bus_read(A_CTRL, 32'h0, "ctrl_back_to_back_no_ovr");
        bus_read(A_COUNT, 32'd6, "count_6");

        // ---------------- counter wrap (CNT_WIDTH = 4) ----------------
        for (int k = 0; k < 9; k++) begin
            expect_pulse(2, img_a);
            bus_write(A_CTRL, 32'h1);
            idle(1);
        end
        idle(1);
        bus_read(A_COUNT, 32'd15, "count_15");
        expect_pulse(2, img_a);
        bus_write(A_CTRL, 32'h1);
        idle(2);
        bus_read(A_COUNT, 32'd0, "count_wrap");

        // ---------------- reset while pending ----------------
        sink_busy = 1'b1;
        bus_write(A_SH0, 32'h55);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 32'h1, "pending_before_reset");
        reset = 1'b1;
        idle(2);
        check_direct("midreset_out_port", out_port, '0);
        check_direct("midreset_update_pulse", PW'(update_pulse), '0);
        reset     = 1'b0;
        sink_busy = 1'b0;
        idle(3);
        bus_read(A_CTRL,  32'h0, "ctrl_after_reset");
        bus_read(A_COUNT, 32'h0, "count_after_reset");
        bus_read(A_SH0,   32'h0, "shadow0_after_reset");
        bus_read(A_AC0,   32'h0, "active0_after_reset");
        bus_read(A_AC3,   32'h0, "active3_after_reset");
        idle(3);

        // Anything still queued never showed up.
        while (rd_q.size() > 0) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: read never observed, expected 0x%08h", e.name, e.data);
        end
        while (pulse_q.size() > 0) begin
            pulse_exp_t p;
            p = pulse_q.pop_front();
            checks++;
            failures++;
            $display("FAIL pulse_missing: no update_pulse seen, expected at cycle %0d", p.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_soc_system_pio_shadow_bank
`default_nettype wire
